// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer pattern scheduler: FSM states,
// requester count and the fixed-priority encoder.
package buzz_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [1:0] prio_enc(input logic [N_REQ-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/buzz_sched_tick_gen.sv
// Time-base prescaler: one-cycle tick every TICK_DIV clocks, restartable
// through clr. While clr is high no tick is emitted and the count holds at 0.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // Prescaler counts 0..TICK_DIV-1 and wraps; clr restarts it from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/buzz_sched.sv
// Beep-pattern scheduler: latches request pulses, grants them one at a time
// by fixed priority (bit 0 highest) and plays i+1 beeps for requester i,
// followed by an enforced silent gap.
//
// The grant cycle is a setup cycle: the FSM is already in ON, but the time
// base is held cleared, so every en_buz window, off window and gap is
// exactly its nominal number of cycles measured on en_buz/busy.
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int ON_T     = 100,
  parameter int OFF_T    = 100,
  parameter int GAP_T    = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             stop,
  output logic             en_buz,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       active_id,
  output logic             busy
);

  localparam int MAX_OO = (ON_T > OFF_T) ? ON_T : OFF_T;
  localparam int MAX_T  = (MAX_OO > GAP_T) ? MAX_OO : GAP_T;
  localparam int CW     = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] ON_END  = CW'(ON_T - 1);
  localparam logic [CW-1:0] OFF_END = CW'(OFF_T - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_T - 1);

  state_t           state, state_next;
  logic [N_REQ-1:0] pend, pend_next;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] grant_next;
  logic [1:0]       sel;
  logic [1:0]       beeps_left, beeps_next;
  logic [1:0]       id_next;
  logic [CW-1:0]    tcnt, tcnt_next;
  logic             en_next;
  logic             busy_next;
  logic             tick;
  logic             tick_clr;

  // Time base is held cleared while idle and during the grant cycle.
  assign tick_clr = (state == ST_IDLE) || (grant != '0);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Next-state, phase timing, grant selection and pending-register update.
  always_comb begin
    state_next = state;
    beeps_next = beeps_left;
    tcnt_next  = tcnt;
    grant_next = '0;
    id_next    = active_id;
    pick       = '0;
    sel        = prio_enc(pend);

    case (state)
      ST_IDLE: begin
        tcnt_next = '0;
        if (pend != '0) begin
          pick       = 4'b0001 << sel;
          grant_next = pick;
          id_next    = sel;
          beeps_next = sel;
          state_next = ST_ON;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ON: begin
        if (tick && (tcnt == ON_END)) begin
          tcnt_next  = '0;
          state_next = (beeps_left != 2'd0) ? ST_OFF : ST_GAP;
        end else if (tick) begin
          tcnt_next = tcnt + CW'(1);
        end else begin
          tcnt_next = tcnt;
        end
      end
      ST_OFF: begin
        if (tick && (tcnt == OFF_END)) begin
          tcnt_next  = '0;
          beeps_next = beeps_left - 2'd1;
          state_next = ST_ON;
        end else if (tick) begin
          tcnt_next = tcnt + CW'(1);
        end else begin
          tcnt_next = tcnt;
        end
      end
      ST_GAP: begin
        if (tick && (tcnt == GAP_END)) begin
          tcnt_next  = '0;
          state_next = ST_IDLE;
        end else if (tick) begin
          tcnt_next = tcnt + CW'(1);
        end else begin
          tcnt_next = tcnt;
        end
      end
      default: begin
        tcnt_next  = '0;
        state_next = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a grant decided this cycle.
    if (stop) begin
      state_next = ST_IDLE;
      grant_next = '0;
      id_next    = active_id;
      beeps_next = 2'd0;
      tcnt_next  = '0;
      pick       = '0;
      pend_next  = '0;
    end else begin
      // A request landing on its own grant re-arms the bit.
      pend_next = (pend & ~pick) | req;
    end

    // en_buz follows the ON state but skips the grant (setup) cycle.
    en_next   = !stop && (state_next == ST_ON) && (state != ST_IDLE);
    busy_next = (state_next != ST_IDLE);
  end

  // State, pending bits, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend       <= '0;
      beeps_left <= 2'd0;
      tcnt       <= '0;
      en_buz     <= 1'b0;
      grant      <= '0;
      active_id  <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      beeps_left <= beeps_next;
      tcnt       <= tcnt_next;
      en_buz     <= en_next;
      grant      <= grant_next;
      active_id  <= id_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_buzz_sched.sv
// Directed bench for buzz_sched with TICK_DIV=4, ON_T=2, OFF_T=3, GAP_T=5:
// beep window 8 cycles, beep period 20 cycles, gap 20 cycles.
module tb_buzz_sched;
  import buzz_pkg::*;

  localparam int TD      = 4;
  localparam int ONT     = 2;
  localparam int OFFT    = 3;
  localparam int GAPT    = 5;
  localparam int ON_CYC  = 8;
  localparam int PER_CYC = 20;
  localparam int GAP_CYC = 20;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       stop = 1'b0;
  logic [3:0] req  = 4'b0000;
  logic       en_buz;
  logic [3:0] grant;
  logic [1:0] active_id;
  logic       busy;

  int checks = 0;
  int errors = 0;

  buzz_sched #(
    .TICK_DIV (TD),
    .ON_T     (ONT),
    .OFF_T    (OFFT),
    .GAP_T    (GAPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .stop      (stop),
    .en_buz    (en_buz),
    .grant     (grant),
    .active_id (active_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse req for one cycle; returns at the negedge of the expected grant cycle.
  task automatic start_req(input logic [3:0] v);
    @(negedge clk);
    req = v;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
  endtask

  // Called at the grant-cycle negedge; walks a whole pattern of requester id
  // and the single idle cycle after it. Optionally injects inj_req at two
  // cycle offsets (k=0 is the grant cycle).
  task automatic watch_pattern(input int id, input int inj_a, input int inj_b,
                               input logic [3:0] inj_req, input string tag);
    int         plen;
    int         total;
    int         seg;
    logic       exp_en;
    logic [3:0] exp_g;
    plen  = (id + 1) * ON_CYC + id * (PER_CYC - ON_CYC);
    total = plen + GAP_CYC;
    exp_g = 4'b0001 << id;
    checks++;
    if (grant !== exp_g || busy !== 1'b1 || en_buz !== 1'b0 || active_id !== 2'(id)) begin
      errors++;
      $display("FAIL %s_grant: grant=%b busy=%b en_buz=%b id=%0d, want grant=%b busy=1 en_buz=0 id=%0d",
               tag, grant, busy, en_buz, active_id, exp_g, id);
    end
    req = (inj_a == 0 || inj_b == 0) ? inj_req : 4'b0000;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      seg    = k - 1;
      exp_en = (seg < plen) && ((seg % PER_CYC) < ON_CYC);
      checks++;
      if (en_buz !== exp_en || busy !== 1'b1 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL %s_k%0d: en_buz=%b busy=%b grant=%b, want en_buz=%b busy=1 grant=0000",
                 tag, k, en_buz, busy, grant, exp_en);
      end
      req = (k == inj_a || k == inj_b) ? inj_req : 4'b0000;
    end
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (busy !== 1'b0 || en_buz !== 1'b0 || grant !== 4'b0000 || active_id !== 2'(id)) begin
      errors++;
      $display("FAIL %s_idle: busy=%b en_buz=%b grant=%b id=%0d, want busy=0 en_buz=0 grant=0000 id=%0d",
               tag, busy, en_buz, grant, active_id, id);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    stop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (en_buz !== 1'b0 || grant !== 4'b0000 || active_id !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: en_buz=%b grant=%b id=%0d busy=%b, want all 0",
               en_buz, grant, active_id, busy);
    end
    checks++;
    if (dut.state !== ST_IDLE || dut.pend !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: state=%0d pend=%b, want state=0 pend=0000", dut.state, dut.pend);
    end
  endtask

  task automatic test_single();
    start_req(4'b0100);
    watch_pattern(2, -1, -1, 4'b0000, "single_p2");
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: grant=%b busy=%b, want 0000/0", grant, busy);
    end
  endtask

  task automatic test_priority();
    start_req(4'b1001);
    watch_pattern(0, -1, -1, 4'b0000, "prio_p0");
    @(negedge clk);
    watch_pattern(3, -1, -1, 4'b0000, "prio_p3");
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || active_id !== 2'd3) begin
      errors++;
      $display("FAIL prio_hold: grant=%b busy=%b id=%0d, want 0000/0/3", grant, busy, active_id);
    end
  endtask

  task automatic test_merge();
    start_req(4'b0010);
    // re-request in the grant cycle and again in the first beep
    watch_pattern(1, 0, 3, 4'b0010, "merge_p1");
    @(negedge clk);
    watch_pattern(1, -1, -1, 4'b0000, "merge_replay");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL merge_no_third_c%0d: grant=%b busy=%b, want 0000/0", k, grant, busy);
      end
    end
  endtask

  task automatic test_no_preempt();
    start_req(4'b0100);
    // req[0] lands in the middle of the gap of pattern 2
    watch_pattern(2, 55, -1, 4'b0001, "gap_p2");
    @(negedge clk);
    watch_pattern(0, -1, -1, 4'b0000, "gap_p0");
  endtask

  task automatic test_stop();
    start_req(4'b0100);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL stop_grant: grant=%b, want 0100", grant);
    end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      req = (k == 3) ? 4'b0010 : 4'b0000;
    end
    // cycle 13 sits in the first off phase
    checks++;
    if (en_buz !== 1'b0 || busy !== 1'b1 || dut.pend !== 4'b0010) begin
      errors++;
      $display("FAIL stop_pre: en_buz=%b busy=%b pend=%b, want 0/1/0010", en_buz, busy, dut.pend);
    end
    stop = 1'b1;
    req  = 4'b0001;
    @(negedge clk);
    stop = 1'b0;
    req  = 4'b0000;
    checks++;
    if (busy !== 1'b0 || en_buz !== 1'b0 || dut.pend !== 4'b0000) begin
      errors++;
      $display("FAIL stop_post: busy=%b en_buz=%b pend=%b, want 0/0/0000", busy, en_buz, dut.pend);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || en_buz !== 1'b0) begin
        errors++;
        $display("FAIL stop_quiet_c%0d: grant=%b busy=%b en_buz=%b, want 0000/0/0",
                 k, grant, busy, en_buz);
      end
    end
  endtask

  task automatic test_async_reset();
    start_req(4'b0001);
    repeat (3) @(negedge clk);
    checks++;
    if (en_buz !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: en_buz=%b, want 1", en_buz);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (en_buz !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_async: en_buz=%b busy=%b, want 0/0 before any edge", en_buz, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (en_buz !== 1'b0 || grant !== 4'b0000 || active_id !== 2'd0 || busy !== 1'b0 ||
        dut.state !== ST_IDLE || dut.pend !== 4'b0000) begin
      errors++;
      $display("FAIL areset_post: en_buz=%b grant=%b id=%0d busy=%b state=%0d pend=%b, want all 0",
               en_buz, grant, active_id, busy, dut.state, dut.pend);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_quiet: grant=%b busy=%b, want 0000/0", grant, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_merge();
    test_no_preempt();
    test_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzz_sched.md
# buzz_sched

Beep-pattern scheduler that shares the single buzzer driver between four requesters (user keys, alarm sources). It latches one-cycle request pulses, grants them one at a time by fixed priority, and drives the buzzer driver's `en_buz` input with a timed pattern: requester *i* produces *i+1* beeps. It sits between the key decoder and the buzzer driver in the top level, replacing the direct key-toggles-buzzer wiring.

## Interface
- `TICK_DIV`, 50000: clock cycles per time tick (1 ms at 50 MHz).
- `ON_T`, 100: ticks per beep-on phase. Must be ≥ 1.
- `OFF_T`, 100: ticks per off phase between beeps of one pattern. Must be ≥ 1.
- `GAP_T`, 300: ticks of enforced silence after a pattern, before the next grant. Must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, **asynchronous, active-high**.
- `req`  in  4  request pulses. Bit *i* asks for pattern *i*; bit 0 has the highest priority.
- `stop`  in  1  synchronous abort. Clears all pending requests and the active pattern.
- `en_buz`  out  1  buzzer enable, registered. Goes to the buzzer driver.
- `grant`  out  4  one-hot, one-cycle pulse when a pattern starts.
- `active_id`  out  2  index of the pattern in progress. Holds its last value when idle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Pending register `pend[3:0]`:
  - Set by `req[i]`.
  - Cleared by the grant of bit *i*.
  - If `req[i]` arrives in the same cycle that bit *i* is granted, the bit stays set. The new request is not lost.
  - A repeated request while the bit is already pending merges into it; there is no counting.
- States: IDLE, ON, OFF, GAP.
  - **IDLE**: if `pend != 0`, grant the lowest set index. That cycle: `grant` pulses, `active_id` loads, `beeps_left` loads *i* (remaining after the current beep), tick prescaler and tick counter clear. Next state is ON.
  - **ON**: `en_buz = 1`. After `ON_T` ticks, go to OFF if `beeps_left != 0`, otherwise to GAP.
  - **OFF**: `en_buz = 0`. After `OFF_T` ticks, decrement `beeps_left` and go to ON.
  - **GAP**: `en_buz = 0`. After `GAP_T` ticks, go to IDLE.
- No preemption. A higher-priority request waits until the running pattern and its GAP complete.
- `stop` has priority over everything else in that cycle:
  - next state IDLE, `pend` cleared, `en_buz` 0 next cycle;
  - `req` bits arriving in the same cycle as `stop` are dropped.
- Arithmetic:
  - prescaler is `$clog2(TICK_DIV)` bits and wraps at `TICK_DIV-1`;
  - tick counter is wide enough for `max(ON_T, OFF_T, GAP_T)`;
  - `beeps_left` is 2 bits.
- No undefined encodings. Illegal state goes to IDLE.

## Timing
- Reset values: `en_buz` 0, `grant` 0, `active_id` 0, `busy` 0, `pend` 0, state IDLE, all counters 0. `rst` forces `en_buz` low immediately, with no clock needed.
- Request to grant: `req` sampled at edge *n*, `grant` high in cycle *n+1* if idle.
- `en_buz` rises one cycle after the `grant` pulse. `busy` rises with `grant`.
- Phase lengths, exact:
  - ON is `ON_T·TICK_DIV` cycles;
  - OFF is `OFF_T·TICK_DIV` cycles;
  - GAP is `GAP_T·TICK_DIV` cycles.
- Pattern *i* total, from `en_buz` rise to `busy` fall: `((i+1)·ON_T + i·OFF_T + GAP_T)·TICK_DIV` cycles.
- Back-to-back patterns: the next `grant` comes in the first IDLE cycle after GAP, so IDLE lasts exactly one cycle.

## Structure
- Shared package `buzz_pkg`:
  - state enum (IDLE/ON/OFF/GAP);
  - `N_REQ = 4`;
  - priority-encode function (lowest set bit to index).
- Sub-module `tick_gen`:
  - prescaler with `clr` input;
  - emits a one-cycle `tick` every `TICK_DIV` cycles;
  - reused by the other timed blocks in the design.
- The rest of the block is a single FSM process plus the pending-register logic.

## Test plan
Bench parameters: `TICK_DIV=4`, `ON_T=2`, `OFF_T=3`, `GAP_T=5`.
1. Reset asserted in the middle of an ON phase → `en_buz` drops asynchronously; after release all outputs are 0 and state is IDLE.
2. Single `req=4'b0100` → `grant=4'b0100` one cycle later; three `en_buz` high windows of 8 cycles each, separated by 12-cycle lows; then 20 cycles of GAP; then `busy` falls.
3. `req=4'b1001` in one cycle → pattern 0 runs first (1 beep). Pattern 3 is granted in the first IDLE cycle after pattern 0's GAP and gives 4 beeps.
4. `req[1]` pulsed during pattern 1's ON phase, and again in the exact cycle `grant[1]` fires → pattern 1 replays once after the GAP. Duplicates are merged, not counted.
5. `stop` asserted during OFF with `pend=4'b0010` → `en_buz` stays 0, `busy` falls next cycle, `pend` is cleared, and no later grant occurs.
6. `req[0]` arrives during pattern 2's GAP → no preemption; `grant[0]` comes only after GAP ends.
